// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: instruction memory port, redirect input, decode handshake and status.
interface imem_fetch_ctrl_if;
    logic [31:0] pc;
    logic [31:0] instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        stopped;
    logic        fault;
    logic [31:0] retired_count;

    modport ctrl (
        output pc, out_valid, out_instr, out_pc, stopped, fault, retired_count,
        input  instruction, redirect_valid, redirect_pc, out_ready
    );

    modport env (
        input  pc, out_valid, out_instr, out_pc, stopped, fault, retired_count,
        output instruction, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: PC register, 2-entry {pc, instr} buffer toward decode,
// redirect handling with FETCH/STOPPED/FAULT states.
module imem_fetch_ctrl #(
    parameter int unsigned NUM_INST = 128,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic             clk,
    input  logic             reset,
    imem_fetch_ctrl_if.ctrl  bus
);
    localparam logic [32:0] LIMIT = 33'(NUM_INST) * 33'd4;

    typedef enum logic [1:0] {S_FETCH, S_STOPPED, S_FAULT} state_e;

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [1:0][31:0]  epc_q, epc_d;
    logic [1:0][31:0]  eins_q, eins_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [31:0]       retired_q, retired_d;

    logic        pop, fetch, redir;
    logic [1:0]  cnt_base;
    logic [32:0] pc_inc;

    assign pop    = (cnt_q != 2'd0) && bus.out_ready;
    assign redir  = (state_q != S_FAULT) && bus.redirect_valid;
    // A full buffer still accepts a fetch when the head leaves in the same cycle.
    assign fetch  = (state_q == S_FETCH) && !bus.redirect_valid && ((cnt_q != 2'd2) || pop);
    assign pc_inc = {1'b0, pc_q} + 33'd4;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        epc_d     = epc_q;
        eins_d    = eins_q;
        retired_d = retired_q;
        cnt_base  = cnt_q - {1'b0, pop};
        cnt_d     = cnt_base;

        if (pop) begin
            retired_d = retired_q + 32'd1;
            epc_d[0]  = epc_q[1];
            eins_d[0] = eins_q[1];
        end

        if (redir) begin
            cnt_d = 2'd0;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                state_d = S_FAULT;
            end else begin
                pc_d    = bus.redirect_pc;
                state_d = ({1'b0, bus.redirect_pc} < LIMIT) ? S_FETCH : S_STOPPED;
            end
        end else if (fetch) begin
            epc_d[cnt_base[0]]  = pc_q;
            eins_d[cnt_base[0]] = bus.instruction;
            cnt_d               = cnt_base + 2'd1;
            pc_d                = pc_inc[31:0];
            if (pc_inc >= LIMIT) state_d = S_STOPPED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            epc_q     <= '0;
            eins_q    <= '0;
            cnt_q     <= 2'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            epc_q     <= epc_d;
            eins_q    <= eins_d;
            cnt_q     <= cnt_d;
            retired_q <= retired_d;
        end
    end

    assign bus.pc            = pc_q;
    assign bus.out_valid     = (cnt_q != 2'd0);
    assign bus.out_instr     = (cnt_q != 2'd0) ? eins_q[0] : 32'd0;
    assign bus.out_pc        = (cnt_q != 2'd0) ? epc_q[0]  : 32'd0;
    assign bus.stopped       = (state_q == S_STOPPED);
    assign bus.fault         = (state_q == S_FAULT);
    assign bus.retired_count = retired_q;
endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_INST, default 128, giving the instruction memory depth in 32-bit words.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, giving the first fetch address after reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port pc, output, 32 bits: byte address driven to the instruction memory; the memory ignores bits [1:0].
REQ-006 The block SHALL have port instruction, input, 32 bits: combinational read data for pc, valid in the same cycle.
REQ-007 The block SHALL have port redirect_valid, input, 1 bit: a taken branch or jump from the pipeline.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: the target byte address, sampled when redirect_valid=1.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the buffer head holds a fetched instruction.
REQ-010 The block SHALL have port out_ready, input, 1 bit: decode accepts the head this cycle.
REQ-011 The block SHALL have port out_instr, output, 32 bits: instruction at the buffer head.
REQ-012 The block SHALL have port out_pc, output, 32 bits: byte address of out_instr.
REQ-013 The block SHALL have port stopped, output, 1 bit: fetch PC is at or beyond NUM_INST*4.
REQ-014 The block SHALL have port fault, output, 1 bit: a misaligned redirect was received; sticky.
REQ-015 The block SHALL have port retired_count, output, 32 bits: number of completed out handshakes; wraps modulo 2^32.

Function
REQ-016 The block SHALL hold a 2-entry FIFO of {pc, instruction} pairs, plus a fetch PC register that drives pc directly.
REQ-017 The block SHALL implement three states: FETCH, STOPPED and FAULT.
REQ-018 In FETCH, a fetch SHALL occur in any cycle where the FIFO is not full, or is full with a pop in the same cycle, and redirect_valid=0.
REQ-019 Each fetch SHALL write {pc, instruction} to the FIFO tail at the clock edge and advance pc by 4.
REQ-020 Latency SHALL be one cycle: an instruction fetched in cycle N appears at the head in cycle N+1 if the FIFO was empty.
REQ-021 A pop SHALL occur exactly when out_valid and out_ready are both 1; out_valid SHALL be 1 exactly when the FIFO is non-empty.
REQ-022 out_instr and out_pc SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 When a fetch would advance pc to a value at or beyond NUM_INST*4, the state SHALL move to STOPPED; the fetched entry is still kept.
REQ-024 In STOPPED, no fetches SHALL occur, stopped=1, and the FIFO SHALL drain normally.
REQ-025 A redirect SHALL take priority over any fetch in the same cycle.
REQ-026 On a redirect, any same-cycle pop SHALL complete and count, and all remaining FIFO entries SHALL be flushed at the edge.
REQ-027 On a redirect with redirect_pc[1:0]=0 and redirect_pc < NUM_INST*4, pc SHALL load redirect_pc and the state SHALL become FETCH, including from STOPPED.
REQ-028 On an aligned redirect with redirect_pc >= NUM_INST*4, pc SHALL load redirect_pc and the state SHALL become STOPPED.
REQ-029 On a redirect with redirect_pc[1:0] != 0, the state SHALL become FAULT, fault SHALL become 1, and pc SHALL be unchanged.
REQ-030 In FAULT, the FIFO SHALL be empty, out_valid SHALL be 0, all inputs SHALL be ignored, and the block SHALL leave FAULT only by reset.
REQ-031 The first instruction fetched after a redirect SHALL appear at out_valid one cycle after the redirect edge, giving one bubble cycle.

Reset
REQ-032 While reset=1 at a rising edge, the block SHALL set pc=RESET_PC, state=FETCH, FIFO empty, out_valid=0, stopped=0, fault=0 and retired_count=0.
REQ-033 Reset SHALL override any in-flight redirect, pop or fetch in the same cycle, including reset asserted while in FAULT or STOPPED.
REQ-034 out_instr and out_pc SHALL read 0 while the FIFO is empty.
REQ-035 The first fetch after reset SHALL occur in the first cycle with reset=0.

Verification
REQ-036 The bench SHALL check: reset released, out_ready=1 -> cycle 1 out_valid=1, out_pc=0, out_instr=32'h00400293; cycle 2 out_pc=4, out_instr=32'h45678337; retired_count increments by 1 each cycle.
REQ-037 The bench SHALL check: out_ready=0 for 5 cycles after reset -> FIFO holds pc 0 and 4, pc stays 8, out_pc stays 0; raising out_ready then gives out_pc 0, 4, 8 on consecutive cycles.
REQ-038 The bench SHALL check: redirect_valid=1 with redirect_pc=32'h34 while the head pc=8 and out_ready=1 -> retired_count+1, next cycle out_valid=0, following cycle out_pc=32'h34.
REQ-039 The bench SHALL check: NUM_INST=4 with continuous out_ready -> out_pc 0, 4, 8, 12, then stopped=1 and out_valid=0; a redirect to 0 clears stopped and restarts fetch at 0.
REQ-040 The bench SHALL check: redirect_pc=32'h22 -> fault=1, out_valid=0 held for 10 cycles despite redirects; reset -> fault=0 and fetch restarts at RESET_PC.
REQ-041 The bench SHALL check: redirect and reset asserted together -> after the edge pc=RESET_PC and retired_count=0.
